// File: rtl/alice_tape_pkg.sv
// Shared defaults, FSM state encoding and a saturating-count helper for the
// cassette-tape ADC slicer.
package alice_tape_pkg;

  localparam int ADC_W_DEF      = 12;
  localparam int DEPTH_LOG2_DEF = 9;
  localparam int HYST_DEF       = 100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2
  } tape_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = 16'hFFFF;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tape_ring_ram.sv
// Simple dual-port ring buffer for the running-average window; registered
// read, no reset so it maps onto block RAM.
module tape_ring_ram
  import alice_tape_pkg::*;
#(
  parameter int W  = ADC_W_DEF,
  parameter int AW = DEPTH_LOG2_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [0:(1<<AW)-1];

  // Storage write port and one-cycle registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/adc_tape_slicer.sv
// Slices ADC samples of a cassette signal into bits against a hysteretic
// running average; also reports the sample period between bit changes.
module adc_tape_slicer
  import alice_tape_pkg::*;
#(
  parameter int ADC_W      = ADC_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int HYST       = HYST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_sync,
  output logic              cas_bit,
  output logic [ADC_W-1:0]  avg,
  output logic              warm,
  output logic              sample_valid,
  output logic              edge_pulse,
  output logic [15:0]       period,
  output logic              overrun
);

  localparam int SW = ADC_W + DEPTH_LOG2;
  localparam int CW = ADC_W + 2;
  localparam logic signed [CW-1:0] HYST_C = CW'(HYST);

  tape_state_e           state_r, state_next_s;
  logic                  sync_r;
  logic                  new_s;
  logic [ADC_W-1:0]      data_r;
  logic [ADC_W-1:0]      rd_data_s;
  logic [ADC_W-1:0]      old_s;
  logic [SW-1:0]         sum_r, sum_next_s;
  logic [DEPTH_LOG2-1:0] wr_ptr_r, fill_r;
  logic [ADC_W-1:0]      avg_r;
  logic                  warm_r, cas_r, cas_next_s;
  logic                  sample_valid_r, edge_pulse_r, overrun_r;
  logic [15:0]           cnt_r, period_r;
  logic                  we_s, re_s;
  logic signed [CW-1:0]  new_sx_s, lo_s, hi_s;

  assign new_s = (sync_r != adc_sync);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: one pass IDLE -> READ -> UPDATE per accepted sample.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (new_s) begin
          state_next_s = READ;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ:    state_next_s = UPDATE;
      UPDATE:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // RAM strobes; a reset landing on UPDATE must not commit the write.
  always_comb begin
    re_s = 1'b0;
    we_s = 1'b0;
    case (state_r)
      READ:    re_s = 1'b1;
      UPDATE:  we_s = ~reset;
      default: begin
        re_s = 1'b0;
        we_s = 1'b0;
      end
    endcase
  end

  tape_ring_ram #(
    .W  (ADC_W),
    .AW (DEPTH_LOG2)
  ) u_ring (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_ptr_r),
    .wdata (data_r),
    .re    (re_s),
    .raddr (wr_ptr_r),
    .rdata (rd_data_s)
  );

  // Accumulator and hysteresis slicer; RAM is undefined until the window fills.
  always_comb begin
    if (warm_r) begin
      old_s = rd_data_s;
    end else begin
      old_s = {ADC_W{1'b0}};
    end
    sum_next_s = sum_r - {{DEPTH_LOG2{1'b0}}, old_s} + {{DEPTH_LOG2{1'b0}}, data_r};
    new_sx_s   = signed'({2'b00, data_r});
    lo_s       = signed'({2'b00, avg_r}) - HYST_C;
    hi_s       = signed'({2'b00, avg_r}) + HYST_C;
    if (!warm_r) begin
      cas_next_s = 1'b0;
    end else if (new_sx_s < lo_s) begin
      cas_next_s = 1'b1;
    end else if (new_sx_s > hi_s) begin
      cas_next_s = 1'b0;
    end else begin
      cas_next_s = cas_r;
    end
  end

  // Sample capture, datapath update and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r         <= adc_sync;
      data_r         <= {ADC_W{1'b0}};
      sum_r          <= {SW{1'b0}};
      wr_ptr_r       <= {DEPTH_LOG2{1'b0}};
      fill_r         <= {DEPTH_LOG2{1'b0}};
      avg_r          <= {ADC_W{1'b0}};
      warm_r         <= 1'b0;
      cas_r          <= 1'b0;
      sample_valid_r <= 1'b0;
      edge_pulse_r   <= 1'b0;
      cnt_r          <= 16'd0;
      period_r       <= 16'd0;
      overrun_r      <= 1'b0;
    end else begin
      sync_r         <= adc_sync;
      sample_valid_r <= 1'b0;
      edge_pulse_r   <= 1'b0;
      if (new_s && (state_r == IDLE)) begin
        data_r <= adc_data;
      end
      if (new_s && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end
      if (state_r == UPDATE) begin
        sum_r          <= sum_next_s;
        avg_r          <= sum_next_s[SW-1:DEPTH_LOG2];
        wr_ptr_r       <= wr_ptr_r + DEPTH_LOG2'(1);
        sample_valid_r <= 1'b1;
        cas_r          <= cas_next_s;
        if (!warm_r) begin
          fill_r <= fill_r + DEPTH_LOG2'(1);
          if (&fill_r) begin
            warm_r <= 1'b1;
          end
        end
        if (cas_next_s != cas_r) begin
          edge_pulse_r <= 1'b1;
          period_r     <= sat_inc16(cnt_r);
          cnt_r        <= 16'd0;
        end else begin
          cnt_r <= sat_inc16(cnt_r);
        end
      end
    end
  end

  assign cas_bit      = cas_r;
  assign avg          = avg_r;
  assign warm         = warm_r;
  assign sample_valid = sample_valid_r;
  assign edge_pulse   = edge_pulse_r;
  assign period       = period_r;
  assign overrun      = overrun_r;

endmodule

// File: doc/adc_tape_slicer.md
ADC_TAPE_SLICER -- requirements
Module: adc_tape_slicer

Interface
REQ-001 SHALL have parameter ADC_W, default 12, ADC sample width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 9, running-average window of 2^DEPTH_LOG2 samples.
REQ-003 SHALL have parameter HYST, default 100, hysteresis in ADC counts.
REQ-004 SHALL have port clk, input, 1, sole clock; same domain as the LTC2308 ADC interface (50 MHz).
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port adc_data, input, ADC_W, latest ADC conversion.
REQ-007 SHALL have port adc_sync, input, 1, toggles once per new adc_data.
REQ-008 SHALL have port cas_bit, output, 1, sliced cassette bit fed to the MC-10 cin; inverted polarity, 1 = below average.
REQ-009 SHALL have port avg, output, ADC_W, current running average.
REQ-010 SHALL have port warm, output, 1, window fully populated since reset.
REQ-011 SHALL have port sample_valid, output, 1, one-cycle pulse per processed sample.
REQ-012 SHALL have port edge_pulse, output, 1, one-cycle pulse on each cas_bit change.
REQ-013 SHALL have port period, output, 16, samples between the last two cas_bit changes.
REQ-014 SHALL have port overrun, output, 1, sticky flag set when a sample is dropped.

Function
REQ-015 SHALL detect a new sample when registered adc_sync differs from adc_sync; this is cycle T.
REQ-016 SHALL sequence through FSM IDLE->READ (T+1)->UPDATE (T+2)->IDLE; adc_data SHALL be captured at T.
REQ-017 SHALL, in READ, present ring pointer wr_ptr to the ring RAM read port; read latency is 1 cycle.
REQ-018 SHALL, in UPDATE, compute sum <= sum - old + new, where sum is ADC_W+DEPTH_LOG2 bits wide, write new at wr_ptr, and advance wr_ptr modulo 2^DEPTH_LOG2 (511->0).
REQ-019 SHALL substitute old = 0 while fill count < 2^DEPTH_LOG2, because RAM contents are undefined after reset.
REQ-020 SHALL assert warm from the cycle after the 2^DEPTH_LOG2-th UPDATE and hold it until reset.
REQ-021 SHALL register avg = sum[top:DEPTH_LOG2], i.e. truncating division, at T+3.
REQ-022 SHALL, in UPDATE, compare new against the pre-update avg using signed arithmetic of ADC_W+2 bits, so there is no wrap at 0 or full scale.
REQ-023 SHALL apply these slicing rules: new < avg-HYST -> cas_bit 1; new > avg+HYST -> cas_bit 0; otherwise hold; cas_bit held 0 while warm=0.
REQ-024 SHALL make cas_bit, avg and sample_valid valid at T+3; end-to-end latency is 3 clk.
REQ-025 SHALL maintain a sample counter, 16-bit saturating at 0xFFFF, incremented per UPDATE.
REQ-026 SHALL, on a cas_bit change, set period <= counter+1 (saturating), clear the counter, and pulse edge_pulse at T+3.
REQ-027 SHALL drop any adc_sync toggle detected while the FSM is not IDLE and set overrun; the in-flight sample completes normally.
REQ-028 SHALL NOT queue samples, i.e. no queue depth.

Reset
REQ-029 SHALL, on reset, clear the FSM to IDLE and clear sum, wr_ptr, fill count, counter, avg, cas_bit, warm, sample_valid, edge_pulse, period and overrun, all to 0.
REQ-030 SHALL load the adc_sync register from adc_sync on reset so no spurious sample follows reset release.
REQ-031 SHALL abandon any sample in flight on reset mid-operation, with no RAM write and no output pulse.
REQ-032 SHALL NOT clear RAM contents on reset; REQ-019 covers this.

Structure
REQ-033 SHALL place ADC_W, DEPTH_LOG2, HYST defaults and the FSM state enum (IDLE, READ, UPDATE) in shared package alice_tape_pkg.
REQ-034 SHALL implement the ring buffer as one sub-module, tape_ring_ram: simple dual-port, 2^DEPTH_LOG2 x ADC_W, registered read, inferred block RAM, no reset.
REQ-035 SHALL contain the FSM, accumulator, comparator and period counter in adc_tape_slicer itself.

Verification
REQ-036 SHALL cover: 600 samples of constant 2048 -> warm rises after sample 512, avg=2048 from then on, cas_bit=0, overrun=0.
REQ-037 SHALL cover: after warm, square wave 2348/1748 with 10 samples per half-cycle -> cas_bit toggles every 10 samples, period=10, edge_pulse once per toggle, cas_bit=1 on the 1748 half.
REQ-038 SHALL cover: after warm on 2048, samples 2148 then 1948 (within HYST) -> cas_bit unchanged, no edge_pulse.
REQ-039 SHALL cover: after warm on constant 40, sample 0 -> no underflow false trigger, cas_bit stays 0; after warm on constant 4050, sample 4095 -> cas_bit stays as before.
REQ-040 SHALL cover: two adc_sync toggles 2 clk apart -> first sample processed, sample_valid once, overrun=1, sum reflects only the first sample.
REQ-041 SHALL cover: reset asserted at T+2 of a sample -> no sample_valid, all outputs 0 next cycle, warm requires 512 new samples.
